// File: rtl/dma_pkg.sv
// Shared DMA loopback types: controller opcodes, sequencer states and line geometry.
// The memory controller imports the same opcode enum so both ends agree on encoding.
package dma_pkg;

  localparam int CL_LINE_BITS = 512;
  localparam int LINE_BYTES   = CL_LINE_BITS / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b11
  } mc_opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_GAP,
    ST_WR,
    ST_WR_GAP,
    ST_FIN
  } seq_state_t;

endpackage

// File: rtl/dma_loopback_seq_if.sv
// Word-serial memory-controller port: the sequencer drives op/addr/wdata, the controller answers.
// master = sequencer side, slave = controller side.
interface dma_loopback_seq_if #(
  parameter int WORD_SIZE     = 32,
  parameter int ADDR_BITCOUNT = 64
);
  import dma_pkg::*;

  logic                     mc_ready;
  logic                     mc_tx_done;
  logic                     mc_rd_valid;
  logic [WORD_SIZE-1:0]     mc_rdata;
  mc_opcode_t               mc_op;
  logic [ADDR_BITCOUNT-1:0] mc_addr;
  logic [WORD_SIZE-1:0]     mc_wdata;

  modport master (
    input  mc_ready, mc_tx_done, mc_rd_valid, mc_rdata,
    output mc_op, mc_addr, mc_wdata
  );

  modport slave (
    output mc_ready, mc_tx_done, mc_rd_valid, mc_rdata,
    input  mc_op, mc_addr, mc_wdata
  );

endinterface

// File: rtl/line_buf.sv
// One cache line of words: single indexed write port, combinational read port.
// Cleared on reset so the idle write-data mux presents zero.
module line_buf #(
  parameter  int WPL       = 16,
  parameter  int WORD_SIZE = 32,
  localparam int IW        = $clog2(WPL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [IW-1:0]        widx_i,
  input  logic [WORD_SIZE-1:0] wdat_i,
  input  logic [IW-1:0]        ridx_i,
  output logic [WORD_SIZE-1:0] rdat_o
);

  logic [WORD_SIZE-1:0] mem_q [WPL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WPL; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdat_i;
    end
  end

  assign rdat_o = mem_q[ridx_i];

endmodule

// File: rtl/dma_loopback_seq.sv
// Copies num_lines cache lines src->dst through the word-serial controller, XOR-summing every word read.
// First op 1 cycle after start; controller stalls via mc_ready (op issue / write accept) and mc_tx_done.
module dma_loopback_seq #(
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 8 * dma_pkg::LINE_BYTES,
  parameter int ADDR_BITCOUNT = 64,
  parameter int LINE_CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_BITCOUNT-1:0] src_addr_i,
  input  logic [ADDR_BITCOUNT-1:0] dst_addr_i,
  input  logic [LINE_CNT_W-1:0]    num_lines_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WORD_SIZE-1:0]     checksum_o,
  dma_loopback_seq_if.master       mc
);
  import dma_pkg::*;

  localparam int WPL = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int IW  = $clog2(WPL);
  localparam logic [IW-1:0]            WI_LAST   = IW'(WPL - 1);
  localparam logic [IW:0]              WPL_CNT   = (IW + 1)'(WPL);
  localparam logic [ADDR_BITCOUNT-1:0] LINE_STEP = ADDR_BITCOUNT'(CL_SIZE_WIDTH / 8);

  seq_state_t               state_q;
  mc_opcode_t               op_q;
  logic [ADDR_BITCOUNT-1:0] addr_q, src_q, dst_q, off_q;
  logic [LINE_CNT_W-1:0]    nl_q, li_q;
  logic [IW-1:0]            wi_q;
  logic [IW:0]              sent_q;
  logic                     acc_q, busy_q, done_q;
  logic [WORD_SIZE-1:0]     csum_q;

  logic                     in_win, buf_we;
  logic [IW-1:0]            rd_idx;
  logic [WORD_SIZE-1:0]     buf_rdat;
  logic [LINE_CNT_W-1:0]    li_d;
  logic [ADDR_BITCOUNT-1:0] off_d;

  // Write window: WPL cycles starting the cycle after the controller accepted the write op.
  assign in_win = (state_q == ST_WR) && acc_q && (sent_q < WPL_CNT);
  assign buf_we = (state_q == ST_RD) && mc.mc_rd_valid;
  assign rd_idx = in_win ? wi_q : '0;
  assign li_d   = li_q + 1'b1;
  assign off_d  = off_q + LINE_STEP;

  line_buf #(.WPL(WPL), .WORD_SIZE(WORD_SIZE)) u_line_buf (
    .clk    (clk),
    .rst    (rst),
    .we_i   (buf_we),
    .widx_i (wi_q),
    .wdat_i (mc.mc_rdata),
    .ridx_i (rd_idx),
    .rdat_o (buf_rdat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= IDLE;
      addr_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      off_q   <= '0;
      nl_q    <= '0;
      li_q    <= '0;
      wi_q    <= '0;
      sent_q  <= '0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csum_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          op_q <= IDLE;
          if (start_i) begin
            src_q  <= src_addr_i;
            dst_q  <= dst_addr_i;
            nl_q   <= num_lines_i;
            addr_q <= src_addr_i;
            off_q  <= '0;
            li_q   <= '0;
            wi_q   <= '0;
            csum_q <= '0;
            busy_q <= 1'b1;
            if (num_lines_i == '0) begin
              state_q <= ST_FIN;
            end else begin
              state_q <= ST_RD;
              op_q    <= mc.mc_ready ? READ : IDLE;
            end
          end
        end
        ST_RD: begin
          if (mc.mc_ready) op_q <= READ;
          if (mc.mc_rd_valid) begin
            csum_q <= csum_q ^ mc.mc_rdata;
            wi_q   <= (wi_q == WI_LAST) ? '0 : wi_q + 1'b1;
          end
          if (mc.mc_tx_done) begin
            op_q    <= IDLE;
            state_q <= ST_RD_GAP;
          end
        end
        ST_RD_GAP: begin
          wi_q    <= '0;
          sent_q  <= '0;
          acc_q   <= 1'b0;
          op_q    <= WRITE;
          addr_q  <= dst_q + off_q;
          state_q <= ST_WR;
        end
        ST_WR: begin
          if (mc.mc_ready) acc_q <= 1'b1;
          if (in_win) begin
            sent_q <= sent_q + 1'b1;
            if (wi_q != WI_LAST) wi_q <= wi_q + 1'b1;
          end
          if (mc.mc_tx_done) begin
            op_q    <= IDLE;
            state_q <= ST_WR_GAP;
          end
        end
        ST_WR_GAP: begin
          li_q  <= li_d;
          wi_q  <= '0;
          off_q <= off_d;
          if (li_d == nl_q) begin
            state_q <= ST_FIN;
          end else begin
            state_q <= ST_RD;
            op_q    <= mc.mc_ready ? READ : IDLE;
            addr_q  <= src_q + off_d;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign checksum_o  = csum_q;
  assign mc.mc_op    = op_q;
  assign mc.mc_addr  = addr_q;
  assign mc.mc_wdata = buf_rdat;

endmodule
